// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences one core load/store at a time into the data memory (IDLE -> ACCESS -> RESP).
// Optional `define MAU_STATS_EN adds saturating load/store/error counters (load_cnt, store_cnt, err_cnt).
module mem_access_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
`ifdef MAU_STATS_EN
  ,
  output logic [15:0]           load_cnt,
  output logic [15:0]           store_cnt,
  output logic [15:0]           err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int WIDX_W = ADDR_WIDTH - 2;
  // One extra bit so a memory filling the whole index space still compares correctly.
  localparam logic [WIDX_W:0] MEM_WORDS = (WIDX_W + 1)'(MEM_SIZE);

  state_t state;
  logic   acc_we;
  logic   req_legal;

  always_comb begin
    req_legal = 1'b1;
    if (req_we)
      req_legal = (req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      req_legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    case (req_funct3[1:0])
      2'b01:   if (req_addr[0]) req_legal = 1'b0;
      2'b10:   if (req_addr[1:0] != 2'b00) req_legal = 1'b0;
      default: ;
    endcase
    if ({1'b0, req_addr[ADDR_WIDTH-1:2]} >= MEM_WORDS)
      req_legal = 1'b0;
  end

`ifdef MAU_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc_we      <= 1'b0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_funct3  <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
`ifdef MAU_STATS_EN
      load_cnt    <= '0;
      store_cnt   <= '0;
      err_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            acc_we     <= req_we;
            resp_rdata <= '0;
            req_ready  <= 1'b0;
            if (req_legal) begin
              state       <= ACCESS;
              resp_err    <= 1'b0;
              mem_wr_en   <= req_we;
              mem_funct3  <= req_funct3;
              mem_addr    <= req_addr;
              mem_wr_data <= req_wdata;
            end else begin
              // Illegal requests skip the memory entirely and answer one cycle later.
              state      <= RESP;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
`ifdef MAU_STATS_EN
              err_cnt    <= sat_inc(err_cnt);
`endif
            end
          end
        end
        ACCESS: begin
          mem_wr_en  <= 1'b0;
          if (!acc_we)
            resp_rdata <= mem_rd_data;
          resp_valid <= 1'b1;
          state      <= RESP;
`ifdef MAU_STATS_EN
          if (acc_we) store_cnt <= sat_inc(store_cnt);
          else        load_cnt  <= sat_inc(load_cnt);
`endif
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_wr_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
